// File: rtl/usb_tx_phy.sv
// usb_tx_phy: full-speed USB transmit front end (SYNC/EOP framing, bit stuffing, NRZI, pad encoding).
// Optional packet abort on TxValid_i loss is built when USB_TX_ABORT_EN is defined.
module usb_tx_phy #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phy_tx_mode,
    input  logic [7:0] DataOut_i,
    input  logic       TxValid_i,
    output logic       TxReady_o,
    output logic       txdp,
    output logic       txdn,
    output logic       txoe
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

`ifdef USB_TX_ABORT_EN
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, EOP3, ABORT} stateT;
`else
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, EOP3} stateT;
`endif

    stateT       state, stateNext;
    logic [CW-1:0] bitCnt;
    logic [7:0]  sr, srNext;
    logic [2:0]  bitIdx, idxNext;
    logic [2:0]  onesCnt, onesNext;
    logic        line, lineNext;
    logic        se0, se0Next;
    logic        oeNext;
    logic        launch, launchBit;
    logic        strobe, stuffDue, boundary, abortNow;

    assign strobe   = bitCnt == LAST;
    assign stuffDue = onesCnt == 3'd6;
    assign boundary = (state == SYNC || state == DATA) && bitIdx == 3'd0 && !stuffDue;

`ifdef USB_TX_ABORT_EN
    logic tvPrev, rdyPrev, abortPend;
    assign abortNow = abortPend || (state == DATA && tvPrev && !TxValid_i && !rdyPrev);

    // track TxValid_i falling mid-byte; a fall right after a TxReady_o pulse is a normal packet end
    always_ff @(posedge clk) begin
        if (rst) begin
            tvPrev    <= 1'b0;
            rdyPrev   <= 1'b0;
            abortPend <= 1'b0;
        end else begin
            tvPrev    <= TxValid_i;
            rdyPrev   <= TxReady_o;
            abortPend <= state == DATA && !strobe && abortNow;
        end
    end
`else
    assign abortNow = 1'b0;
`endif

    assign TxReady_o = strobe && boundary && TxValid_i && !abortNow;
    assign txdp      = line & ~se0;
    assign txdn      = phy_tx_mode ? (~line & ~se0) : se0;

    // state register, bit-time counter and launched line state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bitCnt  <= '0;
            sr      <= '0;
            bitIdx  <= '0;
            onesCnt <= '0;
            line    <= 1'b1;
            se0     <= 1'b0;
            txoe    <= 1'b1;
        end else begin
            state   <= stateNext;
            bitCnt  <= strobe ? '0 : bitCnt + CW'(1);
            sr      <= srNext;
            bitIdx  <= idxNext;
            onesCnt <= onesNext;
            line    <= lineNext;
            se0     <= se0Next;
            txoe    <= oeNext;
        end
    end

    // next state and the bit launched on each strobe edge (a launched 0 toggles the line)
    always_comb begin
        stateNext = state;
        srNext    = sr;
        idxNext   = bitIdx;
        onesNext  = onesCnt;
        lineNext  = line;
        se0Next   = se0;
        oeNext    = txoe;
        launch    = 1'b0;
        launchBit = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: if (TxValid_i) begin
                    stateNext = SYNC;
                    srNext    = 8'h40;
                    idxNext   = 3'd1;
                    oeNext    = 1'b0;
                    launch    = 1'b1;
                end
                SYNC, DATA: begin
                    if (abortNow) begin
`ifdef USB_TX_ABORT_EN
                        stateNext = ABORT;
                        idxNext   = 3'd1;
                        onesNext  = 3'd0;
`endif
                    end else if (stuffDue) begin
                        launch = 1'b1;
                    end else if (bitIdx == 3'd0) begin
                        if (TxValid_i) begin
                            stateNext = DATA;
                            srNext    = {1'b0, DataOut_i[7:1]};
                            idxNext   = 3'd1;
                            launch    = 1'b1;
                            launchBit = DataOut_i[0];
                        end else begin
                            stateNext = EOP1;
                            se0Next   = 1'b1;
                        end
                    end else begin
                        srNext    = sr >> 1;
                        idxNext   = bitIdx + 3'd1;
                        launch    = 1'b1;
                        launchBit = sr[0];
                    end
                end
                EOP1: stateNext = EOP2;
                EOP2: begin
                    stateNext = EOP3;
                    se0Next   = 1'b0;
                    lineNext  = 1'b1;
                end
                EOP3: begin
                    stateNext = IDLE;
                    oeNext    = 1'b1;
                end
`ifdef USB_TX_ABORT_EN
                ABORT: if (bitIdx == 3'd0) begin
                    stateNext = EOP1;
                    se0Next   = 1'b1;
                end else begin
                    idxNext = bitIdx + 3'd1;
                end
`endif
                default: stateNext = IDLE;
            endcase
        end
        if (launch) begin
            lineNext = launchBit ? line : ~line;
            onesNext = launchBit ? onesCnt + 3'd1 : 3'd0;
        end
    end

endmodule
